// File: rtl/latency_memory.sv
// latency_memory: line-wide memory with fixed, counter-timed read/write response latency
module latency_memory #(
    parameter int    ADDR_WIDTH    = 16,
    parameter int    LINE_WIDTH    = 256,
    parameter int    READ_LATENCY  = 25,
    parameter int    WRITE_LATENCY = 25,
    parameter string INIT_FILE     = "memory.lst"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [LINE_WIDTH-1:0]   wdata,
    input  logic [LINE_WIDTH/8-1:0] wmask,
    output logic                    resp,
    output logic [LINE_WIDTH-1:0]   rdata,
    output logic                    busy
);
    localparam int BYTES   = LINE_WIDTH / 8;
    localparam int OFFSET  = $clog2(BYTES);
    localparam int IDX_W   = ADDR_WIDTH - OFFSET;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BYTES-1:0]        wmask_q, wmask_d;
    logic                    wr_q, wr_d;
    logic                    resp_q, resp_d;
    logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
    logic [LINE_WIDTH-1:0]   line_w;
    logic                    access;
    logic [LINE_WIDTH-1:0]   mem [2**IDX_W];

    generate
        if (OFFSET > 0) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^address[OFFSET-1:0];
        end
    endgenerate

    assign access = (state_q == BUSY) && (cnt_q == '0);

    // Post-write line: latched masked bytes merged over the stored line
    always_comb begin
        line_w = mem[idx_q];
        for (int i = 0; i < BYTES; i++)
            if (wmask_q[i]) line_w[8*i +: 8] = wdata_q[8*i +: 8];
    end

    // Next-state: accept in IDLE, count down in BUSY, one dead cycle in RESPOND
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        wr_d    = wr_q;
        resp_d  = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (read | write) begin
                state_d = BUSY;
                idx_d   = address[ADDR_WIDTH-1:OFFSET];
                wdata_d = wdata;
                wmask_d = wmask;
                wr_d    = write;
                cnt_d   = write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            end
            BUSY: if (access) begin
                state_d = RESPOND;
                resp_d  = 1'b1;
                rdata_d = wr_q ? line_w : mem[idx_q];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers; reset aborts any request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage update happens only on the completing edge of a write
    always_ff @(posedge clk) begin
        if (access && wr_q) mem[idx_q] <= line_w;
    end

    assign resp  = resp_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_latency_memory.sv
// tb_latency_memory: scoreboard bench for a default-latency and a 3/7-latency instance
module tb_latency_memory;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         read = 1'b0, write = 1'b0, sel = 1'b0;
    logic [15:0]  address = '0;
    logic [255:0] wdata = '0;
    logic [31:0]  wmask = '0;
    logic         resp_s, busy_s, resp_f, busy_f;
    logic [255:0] rdata_s, rdata_f;
    logic         resp, busy;
    logic [255:0] rdata;
    int           n_tests = 0, n_fail = 0, cyc = 0, last_resp = 0;
    logic         prev_resp = 1'b0;
    logic [255:0] mdl [int];
    logic [255:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    latency_memory #(.INIT_FILE("")) u_slow (
        .clk(clk), .rst_n(rst_n), .read(read & ~sel), .write(write & ~sel),
        .address(address), .wdata(wdata), .wmask(wmask),
        .resp(resp_s), .rdata(rdata_s), .busy(busy_s)
    );

    latency_memory #(.READ_LATENCY(3), .WRITE_LATENCY(7), .INIT_FILE("")) u_fast (
        .clk(clk), .rst_n(rst_n), .read(read & sel), .write(write & sel),
        .address(address), .wdata(wdata), .wmask(wmask),
        .resp(resp_f), .rdata(rdata_f), .busy(busy_f)
    );

    assign resp  = sel ? resp_f : resp_s;
    assign busy  = sel ? busy_f : busy_s;
    assign rdata = sel ? rdata_f : rdata_s;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rnd_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // A resp pulse must never last into a second cycle
    always @(negedge clk) begin
        if (prev_resp) check("resp_width", resp, 1'b0);
        prev_resp = resp;
    end

    task automatic xact(input logic s, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [255:0] d, input logic [31:0] m, input logic b2b);
        int key, lat, acc, n, nb;
        logic [255:0] e;
        sel = s;
        address = a; wdata = d; wmask = m; read = rd; write = wr;
        key = (s ? 4096 : 0) + int'(a[15:5]);
        e = mdl[key];
        if (wr) begin
            for (int i = 0; i < 32; i++) if (m[i]) e[8*i +: 8] = d[8*i +: 8];
            mdl[key] = e;
        end
        exp_q.push_back(e);
        lat = s ? (wr ? 7 : 3) : 25;
        @(negedge clk);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        check("accept", busy, 1'b1);
        acc = cyc;
        if (b2b) check("gap", 256'(acc - last_resp), 256'd2);
        address = a ^ 16'h00A0; wdata = ~d; wmask = ~m;
        nb = 1; n = 0;
        while (!resp && n < 100) begin @(negedge clk); n++; if (busy) nb++; end
        check("latency", 256'(cyc - acc), 256'(lat));
        check("busy_cycles", 256'(nb), 256'(lat + 1));
        check("rdata", rdata, exp_q.size() > 0 ? exp_q.pop_front() : 'x);
        last_resp = cyc;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, acc;
        logic [255:0] pat;
        repeat (3) @(negedge clk);
        check("rst_resp_s", resp_s, 1'b0);
        check("rst_busy_s", busy_s, 1'b0);
        check("rst_rdata_s", rdata_s, '0);
        check("rst_resp_f", resp_f, 1'b0);
        check("rst_busy_f", busy_f, 1'b0);
        check("rst_rdata_f", rdata_f, '0);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++)
            xact(1'b0, 1'b0, 1'b1, 16'(i * 32), rnd_line(), 32'hFFFF_FFFF, i > 1);
        xact(1'b0, 1'b1, 1'b0, 16'h0020, '0, '0, 1'b1);
        xact(1'b0, 1'b0, 1'b1, 16'h0040, {32{8'hA5}}, 32'h0000_000F, 1'b1);
        xact(1'b0, 1'b1, 1'b0, 16'h0040, '0, '0, 1'b1);
        pat = {8{32'h1234_5678}};
        xact(1'b0, 1'b1, 1'b1, 16'h0060, pat, 32'hFFFF_FFFF, 1'b1);
        check("both_high_mem", mdl[3], pat);
        xact(1'b0, 1'b1, 1'b0, 16'h0020, '0, '0, 1'b1);
        repeat (3) @(negedge clk);
        check("idle_resp", resp, 1'b0);
        check("idle_busy", busy, 1'b0);
        sel = 1'b0; address = 16'h00A0; wdata = rnd_line(); wmask = 32'hFFFF_FFFF; write = 1'b1;
        @(negedge clk);
        n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        check("abort_accept", busy, 1'b1);
        acc = cyc;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_resp", resp, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rdata", rdata, '0);
        write = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin @(negedge clk); if (resp) n++; end
        check("abort_no_resp", 256'(n), 256'd0);
        xact(1'b0, 1'b1, 1'b0, 16'h00A0, '0, '0, 1'b0);
        for (int i = 1; i <= 4; i++)
            xact(1'b1, 1'b0, 1'b1, 16'(i * 32), rnd_line(), 32'hFFFF_FFFF, i > 1);
        for (int i = 0; i < 8; i++)
            xact(1'b1, i[0] ? 1'b0 : 1'b1, i[0], 16'(32 * (1 + (i % 4))), rnd_line(), $urandom(), 1'b1);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
